// File: rtl/spi_flash_seq_if.sv
// spi_flash_seq_if: register bus, status and frame enable between the sequencer and the SPI master
interface spi_flash_seq_if;
  logic [1:0] spi_reg_addr;
  logic [1:0] spi_reg_cmd;
  tri   [7:0] spi_reg_data;
  logic [1:0] spi_status;
  logic       spi_en;
  modport master(output spi_reg_addr, spi_reg_cmd, spi_en, inout spi_reg_data, input spi_status);
  modport slave(input spi_reg_addr, spi_reg_cmd, spi_en, inout spi_reg_data, output spi_status);
endinterface

// File: rtl/spi_flash_seq.sv
// spi_flash_seq: turns one flash op into SPI-master register traffic (optional poll timeout: SPI_FLASH_TIMEOUT_EN)
module spi_flash_seq #(
  parameter int CS_GAP = 8
`ifdef SPI_FLASH_TIMEOUT_EN
  , parameter logic [23:0] POLL_MAX = 24'hFFFFFF
`endif
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [1:0]            op_code,
  input  logic [23:0]           op_addr,
  input  logic [8:0]            op_len,
  input  logic [7:0]            wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  err,
  spi_flash_seq_if.master       bus
);
  localparam logic [1:0] REG_CNTL = 2'd0, REG_WDATA = 2'd1, REG_RDATA = 2'd2;
  localparam logic [7:0] CNTL_TX = 8'h02, CNTL_RX = 8'h01;
  localparam logic [1:0] OP_ID = 2'd0, OP_RD = 2'd1, OP_PP = 2'd2;
  typedef enum logic [3:0] {IDLE, CFG_TX, FRAME_ON, TX_WAIT, TX_WR, RX_CFG, RX_WAIT, RX_RD, FRAME_OFF, DONE} state_t;
  typedef enum logic [1:0] {F_WREN, F_CMD, F_POLL} frame_t;
  state_t state, state_n;
  frame_t fk;
  logic [1:0] op_q, cmd, addr;
  logic [23:0] addr_q;
  logic [8:0] len_q, cnt;
  logic [2:0] pos, hdr_len;
  logic [7:0] gap, opcode, tx_byte, wdata;
  logic wip, en, tx_data, in_hdr, more_tx, rx_pending, gap_done, last_frame, timeout, accept;
  assign hdr_len = (fk == F_CMD && op_q != OP_ID) ? 3'd4 : 3'd1;
  assign tx_data = fk == F_CMD && op_q == OP_PP;
  assign in_hdr = pos != hdr_len;
  assign more_tx = in_hdr || (tx_data && cnt != 9'd0);
  assign rx_pending = !tx_data && cnt != 9'd0;
  assign gap_done = gap == 8'(CS_GAP - 1);
  assign last_frame = (fk == F_CMD && !op_q[1]) || (fk == F_POLL && (!wip || timeout));
  assign accept = state == IDLE && op_valid && op_ready;
  assign opcode = fk == F_WREN ? 8'h06 : fk == F_POLL ? 8'h05 :
                  op_q == OP_ID ? 8'h9F : op_q == OP_RD ? 8'h03 : op_q == OP_PP ? 8'h02 : 8'h20;
  assign tx_byte = pos == 3'd0 ? opcode : pos == 3'd1 ? addr_q[23:16] :
                   pos == 3'd2 ? addr_q[15:8] : pos == 3'd3 ? addr_q[7:0] : wr_data;
  assign wdata = state == CFG_TX ? CNTL_TX : state == RX_CFG ? CNTL_RX : tx_byte;
  assign bus.spi_reg_data = cmd == 2'b01 ? wdata : 8'bz;
  assign bus.spi_reg_cmd = cmd;
  assign bus.spi_reg_addr = addr;
  assign bus.spi_en = en;
  // next state and per-cycle bus access; every access is a single-cycle strobe
  always_comb begin
    state_n = state;
    cmd = 2'b00;
    addr = 2'd0;
    en = 1'b0;
    wr_ready = 1'b0;
    case (state)
      IDLE: state_n = accept ? CFG_TX : IDLE;
      CFG_TX: begin
        cmd = 2'b01;
        addr = REG_CNTL;
        state_n = FRAME_ON;
      end
      FRAME_ON: begin
        en = 1'b1;
        state_n = TX_WAIT;
      end
      TX_WAIT: begin
        en = 1'b1;
        if (bus.spi_status[1]) state_n = more_tx ? TX_WR : rx_pending ? RX_CFG : FRAME_OFF;
      end
      TX_WR: begin
        en = 1'b1;
        wr_ready = !in_hdr;
        if (in_hdr || wr_valid) begin
          cmd = 2'b01;
          addr = REG_WDATA;
          state_n = TX_WAIT;
        end
      end
      RX_CFG: begin
        en = 1'b1;
        cmd = 2'b01;
        addr = REG_CNTL;
        state_n = RX_WAIT;
      end
      RX_WAIT: begin
        en = 1'b1;
        if (bus.spi_status[0]) state_n = RX_RD;
      end
      RX_RD: begin
        en = 1'b1;
        cmd = 2'b10;
        addr = REG_RDATA;
        state_n = cnt == 9'd1 ? FRAME_OFF : RX_WAIT;
      end
      FRAME_OFF: if (gap_done) state_n = last_frame ? DONE : CFG_TX;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state register, op capture, frame/byte bookkeeping and registered host outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      fk <= F_CMD;
      op_q <= 2'd0;
      addr_q <= 24'd0;
      len_q <= 9'd0;
      cnt <= 9'd0;
      pos <= 3'd0;
      gap <= 8'd0;
      wip <= 1'b0;
      op_ready <= 1'b0;
      done <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= 8'd0;
    end else begin
      state <= state_n;
      op_ready <= state_n == IDLE;
      done <= state == DONE;
      rd_valid <= state == RX_RD && fk != F_POLL;
      gap <= state == FRAME_OFF ? gap + 8'd1 : 8'd0;
      if (accept) begin
        op_q <= op_code;
        addr_q <= op_addr;
        len_q <= op_len == 9'd0 ? 9'd256 : op_len;
        fk <= op_code[1] ? F_WREN : F_CMD;
      end
      if (state == FRAME_OFF && state_n == CFG_TX) fk <= fk == F_WREN ? F_CMD : F_POLL;
      if (state == CFG_TX) begin
        pos <= 3'd0;
        cnt <= fk == F_POLL ? 9'd1 : fk == F_WREN ? 9'd0 : op_q == OP_ID ? 9'd3 : op_q[1] && op_q[0] ? 9'd0 : len_q;
      end
      if (state == TX_WR && in_hdr) pos <= pos + 3'd1;
      if ((state == TX_WR && !in_hdr && wr_valid) || state == RX_RD) cnt <= cnt - 9'd1;
      if (state == RX_RD) begin
        rd_data <= bus.spi_reg_data;
        if (fk == F_POLL) wip <= bus.spi_reg_data[0];
      end
    end
  end
`ifdef SPI_FLASH_TIMEOUT_EN
  logic [23:0] polls;
  assign timeout = wip && polls == POLL_MAX - 24'd1;
  // counts completed busy polls and latches err when the limit is reached
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      polls <= 24'd0;
      err <= 1'b0;
    end else if (accept) begin
      polls <= 24'd0;
      err <= 1'b0;
    end else if (state == FRAME_OFF && gap_done && fk == F_POLL) begin
      polls <= polls + 24'd1;
      if (timeout) err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err = 1'b0;
`endif
endmodule
